// File: rtl/pq_pkg.sv
// Shared priority-queue types.
//   KEY_WIDTH / VAL_WIDTH : field widths of one queue entry
//   kv_t                  : packed entry, key in the upper bits
//   bheap_state_t         : sequencing states of the binary-heap queue
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    IDLE,
    SIFT_UP,
    SIFT_DOWN
  } bheap_state_t;

endpackage

// File: rtl/bheap_min3.sv
// Picks the smallest-key entry among a heap parent and its (optional) children.
// Ports:
//   parent          : entry at the current heap index
//   lchild, rchild  : entries at 2*idx and 2*idx+1
//   left_vld        : left child exists (index <= count)
//   right_vld       : right child exists (index <= count)
//   sel             : 0 = parent, 1 = left child, 2 = right child
//   win             : the selected entry
// Ties: parent beats an equal child, left beats an equal right.
module bheap_min3
  import pq_pkg::*;
(
  input  kv_t        parent,
  input  kv_t        lchild,
  input  kv_t        rchild,
  input  logic       left_vld,
  input  logic       right_vld,
  output logic [1:0] sel,
  output kv_t        win
);

  // Strict less-than against the running best gives the tie order for free.
  always_comb begin
    sel = 2'd0;
    win = parent;
    if (left_vld && (lchild.key < win.key)) begin
      sel = 2'd1;
      win = lchild;
    end
    if (right_vld && (rchild.key < win.key)) begin
      sel = 2'd2;
      win = rchild;
    end
  end

endmodule

// File: rtl/bheap_pq.sv
// Binary min-heap priority queue; one sift step per clock.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   enq, deq : commands, sampled only while idle (enq+deq = replace root)
//   kvi      : entry to enqueue {key,val}
//   kvo      : root entry heap[1] (valid when !busy && !empty)
//   empty    : no entries
//   full     : DEPTH entries
//   busy     : a sift is in progress, commands are dropped
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for a command
// SIFT_UP   | bubbling the newly written leaf toward the root
// SIFT_DOWN | pushing the root entry down toward the leaves
module bheap_pq
  import pq_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq,
  input  logic                          deq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
  output logic                          empty,
  output logic                          full,
  output logic                          busy
);

  // One extra bit so 2*idx+1 never wraps.
  localparam int IW = CW + 1;

  kv_t          heap [1:DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  bheap_state_t  state_q, state_d;

  // Two write ports are enough: a swap touches exactly two entries.
  logic          wa_en, wb_en;
  logic [IW-1:0] wa, wb;
  kv_t           wa_d, wb_d;

  logic [IW-1:0] cnt_ext, par_idx, lidx, ridx, dn_child;
  logic          left_vld, right_vld;
  kv_t           cur, par, lkv, rkv, dn_win, last_kv;
  logic [1:0]    dn_sel;

  // Bounded read mux; indices outside 1..DEPTH read as zero.
  function automatic kv_t heap_rd(input logic [IW-1:0] i);
    kv_t r;
    r = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (i == IW'(k)) r = heap[k];
    end
    return r;
  endfunction

  assign cnt_ext   = IW'(count_q);
  assign par_idx   = idx_q >> 1;
  assign lidx      = idx_q << 1;
  assign ridx      = (idx_q << 1) | IW'(1);
  assign left_vld  = (lidx <= cnt_ext);
  assign right_vld = (ridx <= cnt_ext);

  assign cur     = heap_rd(idx_q);
  assign par     = heap_rd(par_idx);
  assign lkv     = heap_rd(lidx);
  assign rkv     = heap_rd(ridx);
  assign last_kv = heap_rd(cnt_ext);

  bheap_min3 u_min3 (
    .parent    (cur),
    .lchild    (lkv),
    .rchild    (rkv),
    .left_vld  (left_vld),
    .right_vld (right_vld),
    .sel       (dn_sel),
    .win       (dn_win)
  );

  assign dn_child = (dn_sel == 2'd1) ? lidx : ridx;

  assign kvo   = heap[1];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wa_en   = 1'b0;
    wa      = '0;
    wa_d    = '0;
    wb_en   = 1'b0;
    wb      = '0;
    wb_d    = '0;
    case (state_q)
      IDLE: begin
        if (enq && deq && !empty) begin
          // Replace: overwrite the root and let it sink; count unchanged.
          wa_en   = 1'b1;
          wa      = IW'(1);
          wa_d    = kvi;
          idx_d   = IW'(1);
          state_d = SIFT_DOWN;
        end else if (enq && !full) begin
          // Also covers enq+deq on an empty heap.
          wa_en   = 1'b1;
          wa      = cnt_ext + IW'(1);
          wa_d    = kvi;
          count_d = count_q + CW'(1);
          idx_d   = cnt_ext + IW'(1);
          state_d = SIFT_UP;
        end else if (deq && !enq && !empty) begin
          count_d = count_q - CW'(1);
          // Removing the only entry needs no sift.
          if (count_q != CW'(1)) begin
            wa_en   = 1'b1;
            wa      = IW'(1);
            wa_d    = last_kv;
            idx_d   = IW'(1);
            state_d = SIFT_DOWN;
          end
        end
      end
      SIFT_UP: begin
        if ((idx_q != IW'(1)) && (cur.key < par.key)) begin
          wa_en = 1'b1;
          wa    = idx_q;
          wa_d  = par;
          wb_en = 1'b1;
          wb    = par_idx;
          wb_d  = cur;
          idx_d = par_idx;
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_DOWN: begin
        if (dn_sel == 2'd0) begin
          state_d = IDLE;
        end else begin
          wa_en = 1'b1;
          wa    = idx_q;
          wa_d  = dn_win;
          wb_en = 1'b1;
          wb    = dn_child;
          wb_d  = cur;
          idx_d = dn_child;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      idx_q   <= IW'(1);
      for (int k = 1; k <= DEPTH; k++) heap[k] <= '0;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      for (int k = 1; k <= DEPTH; k++) begin
        if (wa_en && (wa == IW'(k))) heap[k] <= wa_d;
        if (wb_en && (wb == IW'(k))) heap[k] <= wb_d;
      end
    end
  end

endmodule

// File: tb/tb_bheap_pq.sv
// Directed self-checking bench for bheap_pq (DEPTH = 15).
module tb_bheap_pq;
  import pq_pkg::*;

  localparam int DEPTH = 15;
  localparam int KVW   = KEY_WIDTH + VAL_WIDTH;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enq = 1'b0;
  logic           deq = 1'b0;
  logic [KVW-1:0] kvi = '0;
  logic [KVW-1:0] kvo;
  logic           empty, full, busy;

  int n_pass    = 0;
  int n_total   = 0;
  int last_busy = 0;

  int keys1[6]  = '{13, 12, 10, 15, 3, 9};
  int busy1[6]  = '{1, 2, 2, 1, 3, 2};
  int dkeys[5]  = '{9, 10, 12, 13, 15};
  int dbusy[5]  = '{2, 2, 2, 2, 1};

  bheap_pq #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .enq   (enq),
    .deq   (deq),
    .kvi   (kvi),
    .kvo   (kvo),
    .empty (empty),
    .full  (full),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Entry encoding used throughout: val = key + 100.
  function automatic logic [KVW-1:0] mk(input int k);
    return {KEY_WIDTH'(k), VAL_WIDTH'(k + 100)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cmd(input logic e, input logic d, input int k);
    int n;
    n = 0;
    @(negedge clk);
    enq = e;
    deq = d;
    kvi = mk(k);
    @(negedge clk);
    enq = 1'b0;
    deq = 1'b0;
    while (busy === 1'b1 && n < 16) begin
      n++;
      @(negedge clk);
    end
    last_busy = n;
    chk("busy_settle", 32'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_heap(input string tag, input int exp_keys[$]);
    for (int i = 0; i < exp_keys.size(); i++)
      chk($sformatf("%s_heap%0d", tag, i + 1), 32'(dut.heap[i+1].key), exp_keys[i]);
  endtask

  task automatic chk_prop(input string tag);
    for (int i = 2; i <= int'(dut.count_q); i++)
      chk($sformatf("%s_order%0d", tag, i),
          32'(dut.heap[i].key >= dut.heap[i/2].key), 1);
  endtask

  task automatic print_heap();
    $display("heap count=%0d", dut.count_q);
    for (int i = 1; i <= int'(dut.count_q); i++)
      $display("  [%0d] key=%0d val=%0d", i, dut.heap[i].key, dut.heap[i].val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_kvo", 32'(kvo), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);

    // deq on empty is ignored
    cmd(1'b0, 1'b1, 0);
    chk("deq_empty_busy", last_busy, 0);
    chk("deq_empty_empty", 32'(empty), 1);
    chk("deq_empty_kvo", 32'(kvo), 0);

    // enq+deq on empty behaves as enq
    cmd(1'b1, 1'b1, 7);
    chk("encdeq_empty_busy", last_busy, 1);
    chk("encdeq_empty_count", 32'(dut.count_q), 1);
    chk("encdeq_empty_kvo", 32'(kvo), 32'(mk(7)));

    // Six enqueues
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cmd(1'b1, 1'b0, keys1[i]);
      chk($sformatf("enq%0d_busy", keys1[i]), last_busy, busy1[i]);
    end
    chk("t1_kvo", 32'(kvo), 32'(mk(3)));
    chk("t1_count", 32'(dut.count_q), 6);
    chk("t1_empty", 32'(empty), 0);
    q = {3, 10, 9, 15, 13, 12};
    chk_heap("t1", q);
    chk_prop("t1");
    print_heap();

    // Six dequeues
    for (int i = 0; i < 5; i++) begin
      cmd(1'b0, 1'b1, 0);
      chk($sformatf("deq%0d_kvo", i), 32'(kvo), 32'(mk(dkeys[i])));
      chk($sformatf("deq%0d_busy", i), last_busy, dbusy[i]);
      chk_prop($sformatf("deq%0d", i));
    end
    cmd(1'b0, 1'b1, 0);
    chk("deq_last_busy", last_busy, 0);
    chk("deq_last_empty", 32'(empty), 1);

    // Fill with 15..1; each new key travels to the root
    do_reset();
    for (int k = 15; k >= 1; k--) begin
      cmd(1'b1, 1'b0, k);
      chk($sformatf("fill%0d_busy", k), last_busy, $clog2(16 - k + 1));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_kvo", 32'(kvo), 32'(mk(1)));
    q = {1, 6, 2, 9, 7, 5, 3, 15, 12, 13, 8, 14, 10, 11, 4};
    chk_heap("fill", q);

    // enq while full is dropped
    cmd(1'b1, 1'b0, 0);
    chk("ovf_busy", last_busy, 0);
    chk("ovf_kvo", 32'(kvo), 32'(mk(1)));
    chk("ovf_count", 32'(dut.count_q), 15);
    chk("ovf_full", 32'(full), 1);

    // Replace root with 20 on the full heap
    cmd(1'b1, 1'b1, 20);
    chk("repl_busy", last_busy, 4);
    chk("repl_count", 32'(dut.count_q), 15);
    chk("repl_kvo", 32'(kvo), 32'(mk(2)));
    chk("repl_leaf", 32'(dut.heap[15]), 32'(mk(20)));
    q = {2, 6, 3, 9, 7, 5, 4, 15, 12, 13, 8, 14, 10, 11, 20};
    chk_heap("repl", q);

    // Reset during the first SIFT_UP cycle
    do_reset();
    cmd(1'b1, 1'b0, 5);
    cmd(1'b1, 1'b0, 6);
    cmd(1'b1, 1'b0, 7);
    cmd(1'b1, 1'b0, 8);
    chk("pre_kvo", 32'(kvo), 32'(mk(5)));
    @(negedge clk);
    enq = 1'b1;
    kvi = mk(1);
    @(negedge clk);
    enq = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_kvo", 32'(kvo), 0);
    rst = 1'b0;
    cmd(1'b1, 1'b0, 4);
    chk("post_rst_kvo", 32'(kvo), 32'(mk(4)));
    chk("post_rst_count", 32'(dut.count_q), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bheap_pq.md
# bheap_pq

Binary min-heap priority queue that implements the DUV end of `pq_if`: it accepts enqueue/dequeue commands from the bench-side `tb` modport and presents the highest-priority (smallest-key) entry on `kvo`. Entries live in a register array with implicit 1-based heap indexing. A small FSM performs one sift step per clock, so operations are multi-cycle and the block signals this with `busy`. It sits beside `pheap_pq` as an alternative DUV under the same top-level and bench.

## Interface
- `DEPTH`, default 15 — maximum number of entries (4 heap levels); any value ≥ 2 is legal.
- `CW`, default `$clog2(DEPTH+1)` — width of the internal entry count.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `enq` input 1 — enqueue request, sampled only in IDLE.
- `deq` input 1 — dequeue request, sampled only in IDLE.
- `kvi` input `KEY_WIDTH+VAL_WIDTH` — entry to enqueue, `{key,val}`.
- `kvo` output `KEY_WIDTH+VAL_WIDTH` — root entry `heap[1]`.
- `empty` output 1 — count == 0.
- `full` output 1 — count == DEPTH.
- `busy` output 1 — FSM not in IDLE; commands are ignored while high.

## Operation
- Priority: a smaller key wins. Only keys are compared; the value travels with its key.
- FSM states are IDLE, SIFT_UP and SIFT_DOWN. A register `idx` holds the current heap index.
- In IDLE, one command is accepted per clock. It is decoded from `enq`, `deq`, `empty` and `full`:
  - enq only, not full: write `heap[count+1]=kvi`, count++, idx=count+1, go to SIFT_UP.
  - deq only, not empty: write `heap[1]=heap[count]`, count--, idx=1, go to SIFT_DOWN.
  - deq only, with count==1: count=0, stay in IDLE.
  - enq+deq, not empty (replace, legal even when full): write `heap[1]=kvi`, count unchanged, idx=1, go to SIFT_DOWN.
  - enq+deq while empty: treated as enq only.
  - enq while full, or deq while empty: ignored; no state change.
- SIFT_UP step:
  - If idx==1, or `key(heap[idx]) >= key(heap[idx/2])`, return to IDLE.
  - Otherwise swap the two entries, set idx=idx/2 and stay in SIFT_UP.
- SIFT_DOWN step:
  - Select the smallest of the parent (`idx`) and its children (`2idx`, `2idx+1`). Only children with index ≤ count take part.
  - Tie rules: the parent beats equal children; the left child beats an equal right child.
  - If the parent wins, return to IDLE. Otherwise swap the parent with the winning child, set idx to that child and stay in SIFT_DOWN.
- Equal keys carry no FIFO ordering guarantee.
- Entries at index > count are don't-care and are never compared.

## Timing
- Reset values: count=0, state IDLE, all heap entries 0, so `kvo`=0, `empty`=1, `full`=0, `busy`=0.
- Reset asserted mid-sift abandons the operation; the cycle after reset shows the reset values.
- Command edge: `empty`, `full` and count update on the same edge that accepts the command; `busy` rises the cycle after acceptance.
- Latency: `busy` stays high for (number of swaps + 1) cycles.
  - Worst case is `$clog2(DEPTH+1)` cycles.
  - An enq that needs no swap gives one busy cycle.
  - A deq to empty (count 1→0) gives zero busy cycles.
- `kvo` is a direct view of the `heap[1]` register. It is valid only when `busy`==0 and `empty`==0, and may show intermediate values during SIFT_DOWN.
- Commands asserted while `busy`==1 are dropped, not queued. The bench must wait for `busy`==0 before driving a command.

## Structure
- `pq_pkg` gets no new parameters. It already supplies `KEY_WIDTH`, `VAL_WIDTH` and `kv_t` (`{key,val}` packed); this block uses `kv_t` and adds nothing to the package except the `bheap_state_t` enum (IDLE, SIFT_UP, SIFT_DOWN).
- Sub-module `bheap_min3` is purely combinational. Inputs: three `kv_t` entries plus two child-valid bits. Outputs: a 2-bit winner select (parent/left/right) using the tie rules above.
- `print_pheap`-style debug task `print_heap` dumps count and `heap[1..count]`; it is for simulation only.

## Test plan
- Reset, then enq 13,12,10,15,3,9 in that order, waiting for `busy`==0 between each -> `kvo` key 3, count 6, `empty`=0; heap array satisfies parent ≤ child at every index.
- From that state, six deqs -> keys on `kvo` after each settles are 9,10,12,13,15, then `empty`=1 after the last; no deq ever sees busy>`$clog2(DEPTH+1)` cycles.
- Fill with keys 15 down to 1 (DEPTH=15) -> `full`=1, `kvo` key 1. A 16th enq of key 0 is ignored: `kvo` stays 1 and count stays 15.
- Deq on empty after reset -> no change, `busy` stays 0. Enq+deq on empty with key 7 -> count 1, `kvo` key 7.
- Replace on the full heap from the fill test with kvi key 20 -> count stays 15, `kvo` key 2, and key 20 ends at a leaf.
- Enq key 1 into heap {5,6,7,8}; assert `rst` on the first SIFT_UP cycle -> next cycle `empty`=1, `busy`=0, `kvo`=0.
